// File: rtl/mario_pos_tracker.sv
// Once per video frame, moves the sprite X one bounded step toward the CPU target.
// It also tracks facing direction and the walk-animation frame. All outputs are registered.
module mario_pos_tracker #(
    parameter int MAX_STEP = 4,
    parameter int X_MAX    = 639,
    parameter int SPRITE_W = 16,
    parameter int ANIM_DIV = 6,
    parameter int INIT_X   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_clk,
    input  logic [9:0] target_x,
    output logic [9:0] sprite_x,
    output logic       dir_left,
    output logic       moving,
    output logic [1:0] anim_frame,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_LATCH = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    localparam int                DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0]       TQ_MAX   = 11'(X_MAX - SPRITE_W);
    localparam logic signed [10:0] STEP_POS = 11'(MAX_STEP);
    localparam logic signed [10:0] STEP_NEG = 11'(-MAX_STEP);
    localparam logic [9:0]        STEP_U   = 10'(MAX_STEP);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ANIM_DIV - 1);

    logic [2:0]       sync_q;
    state_t           state_q, state_d;
    logic [9:0]       tq_q, tq_d;
    logic [9:0]       sx_q, sx_d;
    logic             dir_q, dir_d;
    logic             mov_q, mov_d;
    logic [1:0]       anim_q, anim_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;

    logic             frame_edge;
    logic signed [10:0] diff;

    // Three-flop synchroniser; edge taken between the 2nd and 3rd stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
        end
    end

    assign frame_edge = sync_q[1] & ~sync_q[2];
    assign diff       = signed'({1'b0, tq_q}) - signed'({1'b0, sx_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
            tq_q    <= '0;
            sx_q    <= 10'(INIT_X);
            dir_q   <= 1'b0;
            mov_q   <= 1'b0;
            anim_q  <= 2'd0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tq_q    <= tq_d;
            sx_q    <= sx_d;
            dir_q   <= dir_d;
            mov_q   <= mov_d;
            anim_q  <= anim_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tq_d    = tq_q;
        sx_d    = sx_q;
        dir_d   = dir_q;
        mov_d   = mov_q;
        anim_d  = anim_q;
        div_d   = div_q;
        done_d  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (frame_edge) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                tq_d    = ({1'b0, target_x} > TQ_MAX) ? TQ_MAX[9:0] : target_x;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                state_d = ST_WAIT;
                done_d  = 1'b1;
                // Step result always lies between old position and target, so no wrap.
                if (diff > STEP_POS) begin
                    sx_d = sx_q + STEP_U;
                end else if (diff < STEP_NEG) begin
                    sx_d = sx_q - STEP_U;
                end else begin
                    sx_d = tq_q;
                end
                mov_d = (diff != 11'sd0);
                if (diff < 11'sd0) begin
                    dir_d = 1'b1;
                end else if (diff > 11'sd0) begin
                    dir_d = 1'b0;
                end
                if (diff != 11'sd0) begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        anim_d = anim_q + 2'd1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else begin
                    div_d  = '0;
                    anim_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign sprite_x   = sx_q;
    assign dir_left   = dir_q;
    assign moving     = mov_q;
    assign anim_frame = anim_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_mario_pos_tracker.sv
// Bench for mario_pos_tracker: directed frames plus random targets against a frame-level model.
module tb_mario_pos_tracker;

    localparam int MAX_STEP = 4;
    localparam int X_MAX    = 639;
    localparam int SPRITE_W = 16;
    localparam int ANIM_DIV = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [9:0] target_x = '0;
    logic [9:0] sprite_x;
    logic       dir_left;
    logic       moving;
    logic [1:0] anim_frame;
    logic       frame_done;

    int nerr = 0;
    int nchk = 0;
    int pulse_cnt = 0;

    // Frame-level model state
    int m_sx = 0;
    int m_dir = 0;
    int m_mov = 0;
    int m_run = 0;

    mario_pos_tracker #(
        .MAX_STEP(MAX_STEP), .X_MAX(X_MAX), .SPRITE_W(SPRITE_W),
        .ANIM_DIV(ANIM_DIV), .INIT_X(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk), .target_x(target_x),
        .sprite_x(sprite_x), .dir_left(dir_left), .moving(moving),
        .anim_frame(anim_frame), .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_dir = 0; m_mov = 0; m_run = 0;
    endtask

    task automatic model_frame(input int tgt);
        int t;
        int d;
        t = (tgt > X_MAX - SPRITE_W) ? X_MAX - SPRITE_W : tgt;
        d = t - m_sx;
        if (d > MAX_STEP)       m_sx = m_sx + MAX_STEP;
        else if (d < -MAX_STEP) m_sx = m_sx - MAX_STEP;
        else                    m_sx = t;
        m_mov = (d != 0) ? 1 : 0;
        if (d < 0) m_dir = 1;
        else if (d > 0) m_dir = 0;
        m_run = (d != 0) ? m_run + 1 : 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sprite_x"}, 32'(sprite_x), m_sx);
        chk({tag, ".dir_left"}, 32'(dir_left), m_dir);
        chk({tag, ".moving"}, 32'(moving), m_mov);
        chk({tag, ".anim"}, 32'(anim_frame), (m_run / ANIM_DIV) % 4);
    endtask

    // frame_clk is assumed to have risen just before the next clk edge.
    task automatic wait_update(input int tgt, input bit dbl);
        int p0;
        int got_k;
        p0 = pulse_cnt;
        got_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (dbl && k == 1) frame_clk = 1'b0;
            if (dbl && k == 2) frame_clk = 1'b1;
            if (k == 4) target_x = 10'($urandom);
            if (got_k != 0 && k == got_k + 1) chk("frame_done_low", 32'(frame_done), 0);
            if (frame_done && got_k == 0) begin
                got_k = k;
                chk("latency", k, 5);
                model_frame(tgt);
                check_outputs("frame");
            end
        end
        if (got_k == 0) chk("frame_done_seen", 0, 1);
        @(negedge clk);
        chk("pulses_per_frame", pulse_cnt - p0, 1);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input int tgt, input bit dbl);
        @(negedge clk);
        target_x = 10'(tgt);
        frame_clk = 1'b1;
        wait_update(tgt, dbl);
    endtask

    initial begin
        int tgt;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.sprite_x", 32'(sprite_x), 0);
        chk("rst.frame_done", 32'(frame_done), 0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle.sprite_x", 32'(sprite_x), 0);
        chk("idle.dir_left", 32'(dir_left), 0);
        chk("idle.moving", 32'(moving), 0);
        chk("idle.anim", 32'(anim_frame), 0);
        chk("idle.pulses", pulse_cnt, 0);

        // Approach target 10 from 0
        frame(10, 0); chk("tp.x4", 32'(sprite_x), 4);
        frame(10, 0); chk("tp.x8", 32'(sprite_x), 8);
        frame(10, 0); chk("tp.x10", 32'(sprite_x), 10);
        chk("tp.mov10", 32'(moving), 1);
        frame(10, 0); chk("tp.stand", 32'(moving), 0);
        chk("tp.stand_anim", 32'(anim_frame), 0);

        // Clamp at the right edge
        for (int i = 0; i < 300 && m_sx != 620; i++) frame(620, 0);
        chk("reach620", 32'(sprite_x), 620);
        frame(1000, 0); chk("clamp623", 32'(sprite_x), 623);
        frame(1023, 0); chk("hold623", 32'(sprite_x), 623);
        chk("hold.dir", 32'(dir_left), 0);

        // Walk left, then stop while facing left
        for (int i = 0; i < 300 && m_sx != 100; i++) frame(100, 0);
        frame(50, 0); chk("left96", 32'(sprite_x), 96);
        frame(50, 0); chk("left92", 32'(sprite_x), 92);
        chk("left.dir", 32'(dir_left), 1);
        frame(92, 0); chk("stop.moving", 32'(moving), 0);
        chk("stop.dir", 32'(dir_left), 1);

        // Continuous motion: animation cadence
        for (int f = 1; f <= 30; f++) begin
            frame(600, 0);
            if (f % ANIM_DIV == 0) chk("anim_cadence", 32'(anim_frame), (f / ANIM_DIV) % 4);
        end

        // Second edge two cycles after the first is dropped
        frame(600, 1);

        // Reset while in STEP aborts the update
        @(negedge clk);
        target_x = 10'd300;
        frame_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort.sprite_x", 32'(sprite_x), 0);
        chk("abort.dir", 32'(dir_left), 0);
        chk("abort.moving", 32'(moving), 0);
        chk("abort.anim", 32'(anim_frame), 0);
        chk("abort.done", 32'(frame_done), 0);
        model_reset();
        @(negedge clk);
        target_x = 10'd30;
        // frame_clk still high at release counts as one edge
        @(negedge clk);
        reset_n = 1'b1;
        wait_update(30, 0);
        chk("relstart.x", 32'(sprite_x), 4);

        // Random targets, both near and far
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                tgt = m_sx + int'($urandom_range(0, 12)) - 6;
                if (tgt < 0) tgt = 0;
            end else begin
                tgt = int'($urandom_range(0, 1023));
            end
            frame(tgt, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
